trace_tx: RTL

Commit-trace transmitter for the ISA-sim core. Captures every retired instruction (pc, instruction word, optional destination write), buffers the records in a small FIFO and serializes them as framed bytes over a valid/ready byte stream. It is the producing end of the retire-trace interface: the stream feeds an off-chip or bench-side decoder that rebuilds the same records the trace monitor prints.

---
 rtl/trace_pkg.sv | 52 +++++
 rtl/trace_fifo.sv | 55 +++++
 rtl/trace_tx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types for the retire-trace transmitter: record layout, header fields,
// frame lengths and serializer states.
package trace_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned RD_W      = 5;
  localparam int unsigned SEQ_W     = 5;

  localparam int unsigned HDR_START  = 7;
  localparam int unsigned HDR_LOST   = 6;
  localparam int unsigned HDR_SEQ_LO = 1;
  localparam int unsigned HDR_RDV    = 0;

  localparam int unsigned FRAME_LEN_BASE = 9;
  localparam int unsigned FRAME_LEN_RD   = 14;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
    logic              rd_v;
    logic [RD_W-1:0]   rd;
    logic [WORD_W-1:0] rd_data;
    logic              lost;
    logic [SEQ_W-1:0]  seq;
  } trace_rec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PC,
    S_INST,
    S_RDX,
    S_RDD
  } ser_state_t;

  // Frame header byte for a record
  function automatic logic [7:0] make_hdr(input trace_rec_t r);
    logic [7:0] h;
    h = '0;
    h[HDR_START]            = 1'b1;
    h[HDR_LOST]             = r.lost;
    h[HDR_SEQ_LO +: SEQ_W]  = r.seq;
    h[HDR_RDV]              = r.rd_v;
    return h;
  endfunction

  // Little-endian byte i of a 32-bit word
  function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// DEPTH-entry synchronous FIFO of trace records with occupancy count.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  trace_rec_t               wdata,
  input  logic                     pop,
  output trace_rec_t               head_c,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full_c,
  output logic                     empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  trace_rec_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full_c  = (level == LW'(DEPTH));
  assign empty_c = (level == '0);
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;
  assign head_c  = mem[rd_ptr];

  // Record storage, written at the tail
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= AW'(wr_ptr + AW'(1));
      if (do_pop)  rd_ptr <= AW'(rd_ptr + AW'(1));
      case ({do_push, do_pop})
        2'b10:   level <= LW'(level + LW'(1));
        2'b01:   level <= LW'(level - LW'(1));
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trace_tx.sv
// Retire-trace transmitter: captures retired instructions into a FIFO and
// serializes them as framed bytes on a valid/ready stream.
// Optional feature macro: TRACE_RD_EN (send destination write, 14-byte frames).
module trace_tx
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inst_v,
  input  logic [31:0]             pc,
  input  logic [31:0]             inst,
  input  logic                    rd_v,
  input  logic [4:0]              rd,
  input  logic [31:0]             rd_data,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);

  logic [SEQ_W-1:0] seq;
  logic             lost_pending;
  trace_rec_t       wr_rec;
  trace_rec_t       head_c;
  logic             full_c;
  logic             empty_c;
  logic             push_c;
  logic             pop_c;
  logic             accept_c;
  logic             last_c;

  ser_state_t       state;
  logic [1:0]       idx;
  trace_rec_t       frm;

  logic             unused_frm_c;
  assign unused_frm_c = ^{frm.lost, frm.seq};

  // Record to push: destination fields only kept when the feature is built in
  always_comb begin
    wr_rec      = '0;
    wr_rec.pc   = pc;
    wr_rec.inst = inst;
    wr_rec.lost = lost_pending;
    wr_rec.seq  = seq;
`ifdef TRACE_RD_EN
    wr_rec.rd_v    = rd_v;
    wr_rec.rd      = rd;
    wr_rec.rd_data = rd_data;
`endif
  end

`ifndef TRACE_RD_EN
  logic unused_rd_c;
  assign unused_rd_c = ^{rd_v, rd, rd_data};
`endif

  // Full is judged on pre-edge level, so a same-edge pop never rescues a write
  assign push_c   = inst_v && !full_c;
  assign accept_c = tx_valid && tx_ready;
  assign last_c   = accept_c && (idx == 2'd3) &&
                    (((state == S_INST) && !frm.rd_v) || (state == S_RDD));
  assign pop_c    = !empty_c && ((state == S_IDLE) || last_c);

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_c),
    .wdata   (wr_rec),
    .pop     (pop_c),
    .head_c  (head_c),
    .level   (level),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // Sequence number, pending-loss flag and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq          <= '0;
      lost_pending <= 1'b0;
      overflow     <= 1'b0;
    end else if (inst_v) begin
      seq <= SEQ_W'(seq + SEQ_W'(1));
      if (full_c) begin
        lost_pending <= 1'b1;
        overflow     <= 1'b1;
      end else begin
        lost_pending <= 1'b0;
      end
    end
  end

  // Serializer: one byte per accepted handshake, back-to-back frames without a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      frm      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (pop_c) begin
      state    <= S_HDR;
      idx      <= '0;
      frm      <= head_c;
      tx_data  <= make_hdr(head_c);
      tx_valid <= 1'b1;
    end else if (last_c) begin
      state    <= S_IDLE;
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (accept_c) begin
      case (state)
        S_HDR: begin
          state   <= S_PC;
          idx     <= '0;
          tx_data <= word_byte(frm.pc, 2'd0);
        end
        S_PC: begin
          if (idx == 2'd3) begin
            state   <= S_INST;
            idx     <= '0;
            tx_data <= word_byte(frm.inst, 2'd0);
          end else begin
            idx     <= 2'(idx + 2'd1);
            tx_data <= word_byte(frm.pc, 2'(idx + 2'd1));
          end
        end
        S_INST: begin
          if (idx == 2'd3) begin
            state   <= S_RDX;
            idx     <= '0;
            tx_data <= {3'b000, frm.rd};
          end else begin
            idx     <= 2'(idx + 2'd1);
            tx_data <= word_byte(frm.inst, 2'(idx + 2'd1));
          end
        end
        S_RDX: begin
          state   <= S_RDD;
          idx     <= '0;
          tx_data <= word_byte(frm.rd_data, 2'd0);
        end
        S_RDD: begin
          idx     <= 2'(idx + 2'd1);
          tx_data <= word_byte(frm.rd_data, 2'(idx + 2'd1));
        end
        default: begin
          state    <= S_IDLE;
          idx      <= '0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
